bus_rr_arbiter: RTL
===================

// Module: bus_rr_arbiter
// PURPOSE
//  Shares the single simple-bus slave port among N_MASTERS bus masters (core bus adapters, DMA, debug).
//  Round-robin grant, one transaction in flight, transparent forwarding of the granted master's request.
//  Watchdog aborts a transaction the slave never acks.
//  Sits between the per-core bus adapters and the memory/peripheral interconnect.
// PARAMETERS
//  N_MASTERS  2    number of requesting masters (2..8)
//  XLEN       32   address width
//  TIMEOUT    255  max BUSY cycles without i_ack before abort; 0 disables watchdog
// PORTS
//  i_clk        in   1            clock
//  i_rst        in   1            async reset, active low
//  i_m_bus_en   in   N            per-master request; held high until ack/err
//  i_m_wr_rd    in   N            per-master 0=read 1=write
//  i_m_wr_data  in   N*32         per-master write data, master k at [32k+:32]
//  i_m_addr     in   N*XLEN       per-master address, master k at [XLEN*k+:XLEN]
//  i_m_size     in   N*3          per-master size code (funct3 encoding), master k at [3k+:3]
//  o_m_ack      out  N            per-master ack, one-hot, combinational copy of i_ack
//  o_m_err      out  N            per-master timeout pulse, one cycle
//  o_m_rd_data  out  32           read data broadcast to all masters (= i_rd_data)
//  o_grant      out  N            one-hot current owner, 0 when IDLE
//  o_bus_en     out  1            slave request
//  o_wr_rd      out  1            slave direction
//  o_wr_data    out  32           slave write data
//  o_addr       out  XLEN         slave address
//  o_size       out  3            slave size code
//  i_ack        in   1            slave completion
//  i_rd_data    in   32           slave read data
// BEHAVIOUR
//  Reset (async, i_rst=0): state=IDLE, grant idx=0, rr pointer=N-1 (master 0 has priority first), wd counter=0.
//  Outputs in reset: all 0.
//  States: IDLE, BUSY (registered).
//  IDLE:
//   - No request: stay IDLE; o_bus_en=0; o_grant=0.
//   - Any request: search from ptr+1 upward, wrapping; take first requester k.
//   - Register grant=k; next state=BUSY.
//   - Latency: request at edge n -> o_bus_en=1 in the cycle after edge n+1.
//  BUSY (owner k):
//   - Request mux: o_wr_rd/o_wr_data/o_addr/o_size = master k fields, combinational.
//   - o_bus_en = i_m_bus_en[k]; o_grant = onehot(k).
//   - Completion: i_ack=1 -> o_m_ack[k]=1 that cycle; state->IDLE; ptr<=k; wd<=0.
//   - Abort by master: i_m_bus_en[k]=0 -> IDLE next edge; no ack/err; ptr<=k.
//   - Watchdog: wd increments each BUSY cycle without ack.
//   - Timeout: wd==TIMEOUT-1 and no ack -> o_m_err[k]=1 that cycle; IDLE; ptr<=k.
//   - Ack and timeout in same cycle: ack wins, no err.
//  Arbitration rules:
//   - Always at least one IDLE cycle between transactions.
//   - Requests from other masters never preempt BUSY.
//   - Idle-cycle gaps fixed at 1 -> worst-case wait for any master = (N-1) transactions.
//   - o_m_ack/o_m_err for non-owners always 0; ack seen in IDLE is ignored.
//   - Mux outputs when IDLE: 0.
//  Widths: wd counter $clog2(TIMEOUT+1) bits, saturates never (cleared on exit).
//   - ptr/grant $clog2(N_MASTERS) bits; ptr wraps N-1 -> 0.
//  Reset mid-BUSY: immediate IDLE, all outputs 0; slave sees o_bus_en drop asynchronously.
// TESTING
//  1. m0 read addr=0x100 size=2; slave acks 2 cycles later, rd=0xDEADBEEF
//     -> o_bus_en 1 cycle after req; o_m_ack[0] 1 cycle; o_m_rd_data=0xDEADBEEF; IDLE.
//  2. m0,m1 request same cycle after reset, slave 1-cycle ack
//     -> m0 served first, 1 IDLE cycle, then m1; o_grant 01 then 10.
//  3. m0 requests continuously, m1 requests continuously for 6 transactions
//     -> grants alternate 0,1,0,1,0,1; no master starved.
//  4. TIMEOUT=4, m1 write, slave never acks
//     -> o_m_err[1] pulses in 4th BUSY cycle; IDLE next; o_m_ack stays 0.
//  5. i_ack and wd expiry same cycle -> o_m_ack=1, o_m_err=0.
//  6. Mid-BUSY reset and mid-BUSY master drop
//     -> reset: outputs 0 immediately, ptr=N-1.
//     -> master drop: IDLE next edge, no ack, other master granted next.

Source files
------------

// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: per-master request/response vectors plus the shared slave port.
interface bus_rr_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32
);
  logic [N_MASTERS-1:0]      m_bus_en;
  logic [N_MASTERS-1:0]      m_wr_rd;
  logic [N_MASTERS*32-1:0]   m_wr_data;
  logic [N_MASTERS*XLEN-1:0] m_addr;
  logic [N_MASTERS*3-1:0]    m_size;
  logic [N_MASTERS-1:0]      m_ack;
  logic [N_MASTERS-1:0]      m_err;
  logic [31:0]               m_rd_data;
  logic [N_MASTERS-1:0]      grant;
  logic                      bus_en;
  logic                      wr_rd;
  logic [31:0]               wr_data;
  logic [XLEN-1:0]           addr;
  logic [2:0]                size;
  logic                      ack;
  logic [31:0]               rd_data;
  modport master (
    output m_bus_en, m_wr_rd, m_wr_data, m_addr, m_size,
    input  m_ack, m_err, m_rd_data, grant
  );
  modport slave (
    input  bus_en, wr_rd, wr_data, addr, size,
    output ack, rd_data
  );
  modport arbiter (
    input  m_bus_en, m_wr_rd, m_wr_data, m_addr, m_size, ack, rd_data,
    output m_ack, m_err, m_rd_data, grant, bus_en, wr_rd, wr_data, addr, size
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin share of one slave port among N masters, one transaction in flight,
// with a watchdog that aborts transactions the slave never acknowledges.
module bus_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32,
  parameter int TIMEOUT   = 255
) (
  input logic clk,
  input logic rst_n,
  bus_rr_arbiter_if.arbiter bus
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IW-1:0] own, ptr, pick, cand;
  logic [WW-1:0] wd;
  logic [N_MASTERS-1:0] own_oh;
  logic sel_en, sel_wr, busy, live, tmo, done;
  logic [31:0] sel_data;
  logic [XLEN-1:0] sel_addr;
  logic [2:0] sel_size;
  // highest offset first so the requester nearest after ptr is the one left standing
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % N_MASTERS);
      if (bus.m_bus_en[cand]) pick = cand;
    end
  end
  always_comb begin
    sel_en = 1'b0;
    sel_wr = 1'b0;
    sel_data = '0;
    sel_addr = '0;
    sel_size = '0;
    for (int k = 0; k < N_MASTERS; k++)
      if (own == IW'(k)) begin
        sel_en = bus.m_bus_en[k];
        sel_wr = bus.m_wr_rd[k];
        sel_data = bus.m_wr_data[32*k +: 32];
        sel_addr = bus.m_addr[XLEN*k +: XLEN];
        sel_size = bus.m_size[3*k +: 3];
      end
  end
  assign busy = state == BUSY;
  assign own_oh = N_MASTERS'(1) << own;
  assign live = busy & sel_en;
  assign tmo = (TIMEOUT != 0) && wd == WD_LAST && !bus.ack;
  assign done = !sel_en | bus.ack | tmo;
  assign bus.bus_en = live;
  assign bus.grant = busy ? own_oh : '0;
  assign bus.wr_rd = busy & sel_wr;
  assign bus.wr_data = busy ? sel_data : '0;
  assign bus.addr = busy ? sel_addr : '0;
  assign bus.size = busy ? sel_size : '0;
  assign bus.m_ack = live & bus.ack ? own_oh : '0;
  assign bus.m_err = live & tmo ? own_oh : '0;
  assign bus.m_rd_data = bus.rd_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      own <= '0;
      ptr <= IW'(N_MASTERS - 1);
      wd <= '0;
    end else if (state == IDLE) begin
      wd <= '0;
      if (|bus.m_bus_en) begin
        state <= BUSY;
        own <= pick;
      end
    end else if (done) begin
      state <= IDLE;
      ptr <= own;
      wd <= '0;
    end else
      wd <= wd + 1'b1;
endmodule
